// File: rtl/ieee_conv_arbiter.sv
// Round-robin arbiter sharing one fixed-point to IEEE-754 converter among NUM_REQ requesters.
// Latency: result valid 2 cycles after the request handshake (1 for zero operands with IEEE_ARB_ZERO_BYPASS_EN).
// Backpressure: the result is held until out_ready; no new request is accepted until it drains.

module ieee_converter_with_frac #(
    parameter int int_len = 16,
    parameter int fra_len = 16
) (
    input  logic [int_len-1:0] int_part,
    input  logic [fra_len-1:0] frac_part,
    input  logic               sign,
    output logic [31:0]        ieee_out
);
    localparam int W = int_len + fra_len;

    logic [W-1:0]  value;
    logic [W+22:0] norm;
    logic          lead;
    logic [22:0]   mant;
    logic [W-2:0]  low_unused;
    logic [7:0]    expo;
    int            msb;

    always_comb begin
        value = {int_part, frac_part};
        msb   = 0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) msb = i;
        end
        // Leading one lands on the top bit; the 23 bits below it are the truncated mantissa.
        norm = {value, 23'b0} << (W - 1 - msb);
        {lead, mant, low_unused} = norm;
        expo     = 8'(msb + 127 - fra_len);
        ieee_out = lead ? {sign, expo, mant} : 32'h0000_0000;
    end
endmodule

module ieee_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int INT_LEN = 16,
    parameter int FRA_LEN = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*INT_LEN-1:0] req_int,
    input  logic [NUM_REQ*FRA_LEN-1:0] req_frac,
    input  logic [NUM_REQ-1:0]         req_sign,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [ID_W-1:0]            out_id,
    output logic [15:0]                conv_count
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [INT_LEN-1:0]  op_int_q, op_int_d;
    logic [FRA_LEN-1:0]  op_frac_q, op_frac_d;
    logic                op_sign_q, op_sign_d;
    logic [ID_W-1:0]     op_id_q, op_id_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [15:0]         conv_count_q, conv_count_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     win_next;
    logic [INT_LEN-1:0]  win_int;
    logic [FRA_LEN-1:0]  win_frac;
    logic                win_sign;
    logic [31:0]         conv_out;

    ieee_converter_with_frac #(
        .int_len (INT_LEN),
        .fra_len (FRA_LEN)
    ) u_conv (
        .int_part  (op_int_q),
        .frac_part (op_frac_q),
        .sign      (op_sign_q),
        .ieee_out  (conv_out)
    );

    // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        win_int  = '0;
        win_frac = '0;
        win_sign = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_idx) begin
                win_int  = req_int[i*INT_LEN +: INT_LEN];
                win_frac = req_frac[i*FRA_LEN +: FRA_LEN];
                win_sign = req_sign[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_int_d     = op_int_q;
        op_frac_d    = op_frac_q;
        op_sign_d    = op_sign_q;
        op_id_d      = op_id_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        conv_count_d = conv_count_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (win_found && rst_n) begin
                    req_ready[win_idx] = 1'b1;
                    op_int_d  = win_int;
                    op_frac_d = win_frac;
                    op_sign_d = win_sign;
                    op_id_d   = win_idx;
                    rr_ptr_d  = win_next;
                    state_d   = CONV;
`ifdef IEEE_ARB_ZERO_BYPASS_EN
                    if (~|{win_int, win_frac}) begin
                        out_data_d  = 32'h0000_0000;
                        out_id_d    = win_idx;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
`endif
                end
            end
            CONV: begin
                out_data_d  = conv_out;
                out_id_d    = op_id_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    conv_count_d = conv_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_int_q     <= '0;
            op_frac_q    <= '0;
            op_sign_q    <= 1'b0;
            op_id_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            conv_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_int_q     <= op_int_d;
            op_frac_q    <= op_frac_d;
            op_sign_q    <= op_sign_d;
            op_id_q      <= op_id_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign conv_count = conv_count_q;
endmodule

// File: tb/tb_ieee_conv_arbiter.sv
// Bench for ieee_conv_arbiter: fixed vectors, directed arbitration/backpressure/reset sequences, random traffic vs a transaction model.
module tb_ieee_conv_arbiter;
    localparam int N  = 4;
    localparam int IL = 16;
    localparam int FL = 16;
    localparam int IW = 2;
`ifdef IEEE_ARB_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*IL-1:0] req_int;
    logic [N*FL-1:0] req_frac;
    logic [N-1:0]  req_sign;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [IW-1:0] out_id;
    logic [15:0]   conv_count;

    always #5 clk = ~clk;

    ieee_conv_arbiter #(.NUM_REQ(N), .INT_LEN(IL), .FRA_LEN(FL), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_int    (req_int),
        .req_frac   (req_frac),
        .req_sign   (req_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .conv_count (conv_count)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Value = int + frac/2^16; exponent from the position of the top set bit, mantissa truncated.
    function automatic logic [31:0] ref_conv(input logic [15:0] iv, input logic [15:0] fv, input logic s);
        longint unsigned v;
        longint unsigned m;
        int p;
        v = {32'h0, iv, fv};
        if (v == 0) return 32'h0;
        p = 0;
        while ((v >> (p + 1)) != 0) p++;
        m = ((v - (64'd1 << p)) << 23) >> p;
        return {s, 8'(p - FL + 127), m[22:0]};
    endfunction

    task automatic set_req(input int i, input logic [15:0] iv, input logic [15:0] fv, input logic s);
        req_int[i*IL +: IL]  = iv;
        req_frac[i*FL +: FL] = fv;
        req_sign[i]          = s;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        req_int   = '0;
        req_frac  = '0;
        req_sign  = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Expects requester e to win now; completes its transaction with an immediate out_ready.
    task automatic one_txn(input int e, input string name);
        #1;
        chk({name, "_grant"}, {28'h0, req_ready}, 32'(1 << e));
        tick();
        req_valid[e] = 1'b0;
        tick();
        chk({name, "_valid"}, {31'h0, out_valid}, 32'd1);
        chk({name, "_id"}, {30'h0, out_id}, 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] iv;
        logic [15:0] fv;
        logic        s;
        int          req;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        logic [3:0] gp;
        logic [3:0] em;
        bit zero;
        // random-model state
        bit busy, due, m_valid;
        logic [31:0] m_data, pd;
        int m_id, pid, rr, g, clr, sel;
        logic [15:0] m_count;

        tbl[0] = '{16'h0001, 16'h0000, 1'b0, 1, 32'h3F80_0000};
        tbl[1] = '{16'h0003, 16'h8000, 1'b0, 0, 32'h4060_0000};
        tbl[2] = '{16'h0002, 16'h0000, 1'b1, 2, 32'hC000_0000};
        tbl[3] = '{16'h0000, 16'h0000, 1'b1, 3, 32'h0000_0000};
        tbl[4] = '{16'h0000, 16'h8000, 1'b0, 1, 32'h3F00_0000};
        tbl[5] = '{16'h0000, 16'h0001, 1'b0, 0, 32'h3780_0000};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 32'hC77F_FFFF};
        tbl[7] = '{16'h8000, 16'h0000, 1'b0, 3, 32'h4700_0000};

        do_reset();
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_id", {30'h0, out_id}, 32'd0);
        chk("rst_count", {16'h0, conv_count}, 32'd0);
        chk("rst_ready", {28'h0, req_ready}, 32'd0);

        exp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            zero = (tbl[k].iv == 0) && (tbl[k].fv == 0);
            set_req(tbl[k].req, tbl[k].iv, tbl[k].fv, tbl[k].s);
            req_valid = 4'(1 << tbl[k].req);
            out_ready = k[0];
            #1;
            chk("tbl_grant", {28'h0, req_ready}, 32'(1 << tbl[k].req));
            chk("tbl_idle_valid", {31'h0, out_valid}, 32'd0);
            tick();
            req_valid = '0;
            out_ready = 1'b0;
            chk("tbl_t1_valid", {31'h0, out_valid}, {31'h0, BYP && zero});
            chk("tbl_t1_ready", {28'h0, req_ready}, 32'd0);
            tick();
            chk("tbl_t2_valid", {31'h0, out_valid}, 32'd1);
            chk("tbl_data", out_data, tbl[k].exp);
            chk("tbl_id", {30'h0, out_id}, 32'(tbl[k].req));
            chk("tbl_model", out_data, ref_conv(tbl[k].iv, tbl[k].fv, tbl[k].s));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_cnt++;
            chk("tbl_done_valid", {31'h0, out_valid}, 32'd0);
            chk("tbl_count", {16'h0, conv_count}, 32'(exp_cnt));
        end

        // all four requesters at once, downstream always ready
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'h0003, 16'h8000, 1'b0);
        req_valid = 4'hF;
        out_ready = 1'b1;
        gp = '0;
        for (int c = 0; c < 12; c++) begin
            req_valid = req_valid & ~gp;
            #1;
            em = (c % 3 == 0) ? 4'(1 << (c / 3)) : 4'h0;
            chk("all4_ready", {28'h0, req_ready}, {28'h0, em});
            chk("all4_valid", {31'h0, out_valid}, {31'h0, (c % 3 == 2)});
            if (c % 3 == 2) begin
                chk("all4_data", out_data, 32'h4060_0000);
                chk("all4_id", {30'h0, out_id}, 32'(c / 3));
            end
            gp = em;
            tick();
        end
        out_ready = 1'b0;
        chk("all4_count", {16'h0, conv_count}, 32'd4);

        // round-robin pointer after a grant to 2
        do_reset();
        set_req(2, 16'h0001, 16'h0000, 1'b0);
        req_valid = 4'b0100;
        one_txn(2, "rr_2");
        set_req(0, 16'h0005, 16'h0000, 1'b0);
        set_req(3, 16'h0006, 16'h0000, 1'b0);
        req_valid = 4'b1001;
        one_txn(3, "rr_3");
        one_txn(0, "rr_0");

        // backpressure: result must hold for 5 cycles
        do_reset();
        set_req(0, 16'h0002, 16'h0000, 1'b1);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant", {28'h0, req_ready}, 32'd1);
        tick();
        req_valid = 4'b0000;
        set_req(1, 16'h0001, 16'h0000, 1'b0);
        req_valid = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_data", out_data, 32'hC000_0000);
            chk("bp_id", {30'h0, out_id}, 32'd0);
            chk("bp_ready", {28'h0, req_ready}, 32'd0);
            chk("bp_count", {16'h0, conv_count}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_released", {31'h0, out_valid}, 32'd0);
        chk("bp_count1", {16'h0, conv_count}, 32'd1);
        #1;
        chk("bp_next_grant", {28'h0, req_ready}, 32'd2);

        // reset during CONV
        do_reset();
        set_req(0, 16'h0001, 16'h0000, 1'b0);
        req_valid = 4'b0001;
        one_txn(0, "rc_pre");
        set_req(1, 16'h0004, 16'h0000, 1'b0);
        req_valid = 4'b0010;
        #1;
        chk("rc_grant1", {28'h0, req_ready}, 32'd2);
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rc_valid", {31'h0, out_valid}, 32'd0);
            chk("rc_count", {16'h0, conv_count}, 32'd0);
        end
        req_valid = 4'b0011;
        one_txn(0, "rc_first");
        one_txn(1, "rc_second");
        req_valid = '0;

        // random traffic against a transaction-level model
        do_reset();
        busy = 0; due = 0; m_valid = 0; m_data = 0; m_id = 0; m_count = 0;
        rr = 0; clr = -1; pd = 0; pid = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_valid", {31'h0, out_valid}, {31'h0, m_valid});
            chk("rnd_count", {16'h0, conv_count}, {16'h0, m_count});
            if (m_valid) begin
                chk("rnd_data", out_data, m_data);
                chk("rnd_id", {30'h0, out_id}, 32'(m_id));
            end
            if (clr >= 0) req_valid[clr] = 1'b0;
            clr = -1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        sel = $urandom_range(0, 7);
                        if (sel == 0)
                            set_req(i, 16'h0, 16'h0, 1'($urandom));
                        else if (sel == 1)
                            set_req(i, 16'($urandom_range(1, 9)), 16'h0, 1'($urandom));
                        else
                            set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = 1'($urandom);
            #1;
            g = -1;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
                end
            end
            em = (g >= 0) ? 4'(1 << g) : 4'h0;
            chk("rnd_ready", {28'h0, req_ready}, {28'h0, em});
            if (!busy) begin
                if (g >= 0) begin
                    rr   = (g + 1) % N;
                    busy = 1;
                    pid  = g;
                    pd   = ref_conv(req_int[g*IL +: IL], req_frac[g*FL +: FL], req_sign[g]);
                    zero = (req_int[g*IL +: IL] == 0) && (req_frac[g*FL +: FL] == 0);
                    if (BYP && zero) begin
                        m_valid = 1; m_data = 32'h0; m_id = g; due = 0;
                    end else begin
                        due = 1;
                    end
                    clr = g;
                end
            end else if (due) begin
                due = 0; m_valid = 1; m_data = pd; m_id = pid;
            end else if (m_valid && out_ready) begin
                m_valid = 0; m_count = m_count + 16'd1; busy = 0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ieee_conv_arbiter.md
Name: ieee_conv_arbiter

Overview:
- Shares one fixed-point-to-IEEE-754 converter (ieee_converter_with_frac, instantiated internally) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on every requester port and on the single result port.
- Operands and result are registered, so the converter's long combinational priority/shift path sits alone between two flop stages.
- Each result carries the id of the requester it belongs to.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- INT_LEN, 16: integer field width per request, passed to the converter as int_len.
- FRA_LEN, 16: fraction field width per request, passed to the converter as fra_len.
- ID_W, $clog2(NUM_REQ): width of out_id.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: request pending, one bit per requester.
- req_ready  out  NUM_REQ: grant/accept, one-hot or zero.
- req_int  in  NUM_REQ*INT_LEN: magnitude integer part; requester i uses slice [i*INT_LEN +: INT_LEN].
- req_frac  in  NUM_REQ*FRA_LEN: magnitude fraction part, sliced the same way.
- req_sign  in  NUM_REQ: sign bit, 1 = negative.
- out_valid  out  1: result available.
- out_ready  in  1: downstream accepts the result.
- out_data  out  32: IEEE-754 single-precision result (truncated mantissa, as produced by the converter).
- out_id  out  ID_W: index of the requester that owns out_data.
- conv_count  out  16: number of completed output handshakes; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release) clears: state IDLE, rr_ptr 0, operand registers 0, out_valid 0, out_data 0, out_id 0, conv_count 0, req_ready all 0.
- States:
  - IDLE: waits for a request.
  - CONV: operands are registered; converter output settles.
  - HOLD: result held until the downstream handshake.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally; all other bits 0. With no req_valid set, req_ready=0 and the block stays in IDLE.
  - On handshake (cycle T): capture the winner's int, frac and sign plus its id; rr_ptr <= (winner+1) mod NUM_REQ; next state CONV.
- CONV (T+1): register converter output into out_data and the captured id into out_id; out_valid <= 1; next state HOLD. First out_valid cycle is T+2.
- HOLD:
  - out_data and out_id stay stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: out_valid <= 0, conv_count++, next state IDLE.
  - Next accept can occur in the following cycle. Steady-state throughput is 1 result per 3 cycles.
- req_ready is 0 in CONV and HOLD. Requests arriving in those states wait; there is no queueing.
- Requesters keep their valid and data stable until accepted. Dropping req_valid before acceptance is legal and simply removes that requester from arbitration.
- A zero magnitude yields out_data = 0x00000000 regardless of sign (converter rule).
- An out_ready value seen in IDLE or CONV is ignored.
- Reset asserted in CONV or HOLD discards the in-flight result; no out_valid follows reset release.

Optional Feature:
- Macro: IEEE_ARB_ZERO_BYPASS_EN.
- Defined: a request whose int and frac are all zero skips CONV. On the handshake at cycle T, out_data <= 0 and out_id is loaded, out_valid=1 from T+1, and the state goes directly to HOLD.
- Undefined: zero requests take the normal CONV path, with out_valid first seen at T+2.
- All other behaviour is identical in both builds.

Test Plan:
- Req 1 only: int=1, frac=0, sign=0 -> req_ready[1] at T; out_valid at T+2; out_data=0x3F800000; out_id=1; conv_count 0->1 on the handshake.
- Reqs 0..3 all valid simultaneously:
  - Stimulus: int=3, frac=0x8000, sign=0 on all four; out_ready=1.
  - Response: grants in order 0,1,2,3 at 3-cycle spacing; each out_data=0x40600000.
- rr_ptr round-robin after a grant to 2, then reqs 0 and 3 valid -> grant order 3 then 0.
- Backpressure:
  - Stimulus: sign=1, int=2, frac=0; out_ready held 0 for 5 cycles.
  - Response: out_data=0xC0000000 and out_id stable throughout; req_ready=0 throughout; a single handshake when out_ready rises.
- Zero input (int=0, frac=0, sign=1) -> out_data=0x00000000; out_valid at T+1 with IEEE_ARB_ZERO_BYPASS_EN, at T+2 without.
- rst_n pulsed low during CONV -> out_valid stays 0, conv_count=0, rr_ptr=0; the next request from req 0 is granted first.
